tape_in_decoder: RTL and testbench
==================================

Name: tape_in_decoder

Overview:
- Upstream feeder for the port $FF cassette path: conditions the raw 1-bit cassette comparator input (line-in tape audio).
- Produces the filtered tape level and the CPU-visible tape latch.
- Also decodes Colour Genie sync/data pulse cells into bits and sync-aligned bytes for a fast-load path, so audio input is supported alongside .CAS playback.
- Counting uses the CPU clock enable (2.2 MHz), in the same time base as the existing cassette timing.

Parameters:
- FILT_LEN, 4: consecutive agreeing ce samples needed to change tape_level (range 1-15).
- ONE_LO, 13'h0500: minimum cell count for a data pulse (bit '1').
- ONE_HI, 13'h0900: maximum cell count for a data pulse.
- CELL_LO, 13'h0C00: minimum cell count for the next sync pulse (cell end).
- TIMEOUT, 13'h1C00: cell count at which carrier is declared lost.
- SYNC_BYTE, 8'h66: byte that establishes byte alignment.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ce  in  1  CPU-cycle clock enable (pe2M2)
- tape_in  in  1  raw asynchronous cassette comparator bit
- motor  in  1  cassette motor bit (port $FF bit 2)
- latch_clr  in  1  one-clock pulse on CPU write to port $FF
- tape_level  out  1  filtered tape signal
- tape_latch  out  1  set on filtered rising edge; cleared by latch_clr
- carrier  out  1  1 while decoding cells
- bit_valid  out  1  one-clock strobe, decoded bit available
- bit_val  out  1  decoded bit, valid with bit_valid
- synced  out  1  byte alignment achieved
- byte_valid  out  1  one-clock strobe, aligned byte available
- byte_data  out  8  assembled byte, MSB first

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters and shift register cleared.
- Reset is applied on any clock regardless of ce and overrides everything, including mid-byte.
- Synchroniser: 2 flops on every clock.
- Filter:
  - Evaluated on ce only, using a 4-bit run counter.
  - tape_level takes the synced value after FILT_LEN consecutive ce samples that differ from the current level.
  - Total latency: 2 clocks + FILT_LEN ce ticks.
- rise: a ce on which tape_level goes 0->1, internal and registered.
- tape_latch:
  - Set on rise; cleared on latch_clr.
  - rise and latch_clr in the same clock: set wins.
  - Forced 0 while motor=0.
- Cell counter: 13 bits, increments on ce while in CELL, saturates at TIMEOUT.
- FSM:
  - IDLE: on rise -> CELL; counter=0, one_seen=0, carrier=1.
  - CELL, rise with count in [ONE_LO, ONE_HI]: one_seen=1; counter keeps running.
  - CELL, rise with count >= CELL_LO: emit bit_val=one_seen with bit_valid; counter=0, one_seen=0.
  - CELL, rise with count < ONE_LO or in (ONE_HI, CELL_LO): glitch, ignored. A second data pulse in one cell is also ignored.
  - CELL, count reaches TIMEOUT: -> IDLE; carrier=0, synced=0, no bit emitted, bit counter cleared.
  - motor=0 forces IDLE, carrier=0, synced=0 on the next clock.
- Strobes: bit_valid and byte_valid are registered, high exactly 1 clock, asserted the clock after the deciding ce.
- Byte assembly:
  - 8-bit shift register, shifted left with bit_val in the LSB on each bit_valid.
  - Unsynced: after each shift, if the register equals SYNC_BYTE, then synced=1, byte_valid pulses with byte_data=SYNC_BYTE, and the bit counter is set to 0.
  - Synced: bit counter counts 0..7; on the 8th bit byte_valid pulses with the register and the counter wraps to 0.
  - byte_valid coincides with the bit_valid of the completing bit.

Optional Feature:
- Macro: TAPE_IN_ERRCNT_EN.
- Defined:
  - Adds output err_cnt, 8 bits.
  - Increments on each ignored glitch rise and on each timeout.
  - Saturates at 8'hFF.
  - Cleared by reset or latch_clr; latch_clr wins if it coincides with an increment.
- Undefined: port absent, no counter logic; all other behaviour identical.

Test Plan:
- Filter: ce held 1, FILT_LEN=4; tape_in high 3 clocks then low -> tape_level stays 0. High 10 clocks -> tape_level=1 at clock 6 after the first high sample.
- Latch: rise then latch_clr 20 clocks later -> tape_latch 1 then 0. latch_clr coincident with a rise -> tape_latch=1. motor=0 -> tape_latch 0.
- Bit decode, ce every cycle:
  - Sync pulses at 0 and 3582 -> bit_valid with bit_val=0.
  - Added pulse at 1791 -> bit_val=1.
  - Pulse at 1000 -> ignored; bit_val=0, err_cnt=1 with TAPE_IN_ERRCNT_EN defined.
- Alignment: cells encoding 0x00,0x66,0xA5,0x3C -> synced rises with byte_valid/byte_data=8'h66, then byte_valid with 8'hA5 and 8'h3C; no byte_valid before 0x66.
- Timeout: stop pulses mid-byte -> carrier=0, synced=0 at count 13'h1C00, no strobe. Restart with 0x66 -> resync.
- Reset mid-byte (synced, 4 bits in) -> all outputs 0 the next clock; the following byte needs a new SYNC_BYTE.

Source files
------------

// File: rtl/tape_in_decoder.sv
// Cassette line-in conditioner: synchronises and filters tape_in, keeps the CPU tape latch, and decodes
// Colour Genie pulse cells into bits and sync-aligned bytes. Define TAPE_IN_ERRCNT_EN to add err_cnt.
module tape_in_decoder #(
  parameter int unsigned FILT_LEN  = 4,
  parameter logic [12:0] ONE_LO    = 13'h0500,
  parameter logic [12:0] ONE_HI    = 13'h0900,
  parameter logic [12:0] CELL_LO   = 13'h0C00,
  parameter logic [12:0] TIMEOUT   = 13'h1C00,
  parameter logic [7:0]  SYNC_BYTE = 8'h66
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       tape_in,
  input  logic       motor,
  input  logic       latch_clr,
  output logic       tape_level,
  output logic       tape_latch,
  output logic       carrier,
  output logic       bit_valid,
  output logic       bit_val,
  output logic       synced,
  output logic       byte_valid,
  output logic [7:0] byte_data
`ifdef TAPE_IN_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  typedef enum logic {ST_IDLE, ST_CELL} state_e;

  localparam logic [3:0] FILT_CNT = FILT_LEN[3:0];

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [3:0]  run_q, run_d, run_inc;
  logic        latch_q, latch_d;
  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d, cnt_inc;
  logic        one_seen_q, one_seen_d;
  logic        carrier_q, carrier_d;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_val_q, bit_val_d;
  logic [7:0]  sh_q, sh_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        synced_q, synced_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_q, byte_d;

  logic rise, in_cell, cell_end, data_hit, timeout;

  // Run-length filter: the level only flips after FILT_LEN consecutive disagreeing ce samples.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    level_d = level_q;
    run_d   = run_q;
    run_inc = run_q + 4'd1;
    if (ce) begin
      if (sync2_q != level_q) begin
        if (run_inc >= FILT_CNT) begin
          level_d = sync2_q;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end else begin
        run_d = '0;
      end
    end
  end

  assign rise     = level_d & ~level_q;
  assign in_cell  = (state_q == ST_CELL);
  assign cell_end = in_cell && rise && (cnt_q >= CELL_LO);
  assign data_hit = in_cell && rise && !cell_end && !one_seen_q
                    && (cnt_q >= ONE_LO) && (cnt_q <= ONE_HI);
  assign cnt_inc  = cnt_q + 13'd1;
  assign timeout  = in_cell && ce && !cell_end && (cnt_inc >= TIMEOUT);

  // Set has priority over the CPU clear; a stopped motor holds the latch low.
  always_comb begin
    latch_d = latch_q;
    if (latch_clr) latch_d = 1'b0;
    if (rise)      latch_d = 1'b1;
    if (!motor)    latch_d = 1'b0;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    one_seen_d   = one_seen_q;
    carrier_d    = carrier_q;
    bit_valid_d  = 1'b0;
    bit_val_d    = bit_val_q;
    sh_d         = sh_q;
    bit_cnt_d    = bit_cnt_q;
    synced_d     = synced_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d    = ST_CELL;
          cnt_d      = '0;
          one_seen_d = 1'b0;
          carrier_d  = 1'b1;
        end
      end
      ST_CELL: begin
        if (cell_end) begin
          bit_valid_d = 1'b1;
          bit_val_d   = one_seen_q;
          cnt_d       = '0;
          one_seen_d  = 1'b0;
        end else begin
          if (data_hit) one_seen_d = 1'b1;
          if (timeout) begin
            state_d    = ST_IDLE;
            cnt_d      = TIMEOUT;
            carrier_d  = 1'b0;
            synced_d   = 1'b0;
            bit_cnt_d  = '0;
            one_seen_d = 1'b0;
          end else if (ce) begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!motor) begin
      state_d     = ST_IDLE;
      carrier_d   = 1'b0;
      synced_d    = 1'b0;
      bit_cnt_d   = '0;
      one_seen_d  = 1'b0;
      bit_valid_d = 1'b0;
    end

    // Byte assembly rides on the bit strobe so byte_valid lines up with the completing bit.
    if (bit_valid_d) begin
      sh_d = {sh_q[6:0], bit_val_d};
      if (!synced_q) begin
        if (sh_d == SYNC_BYTE) begin
          synced_d     = 1'b1;
          byte_valid_d = 1'b1;
          byte_d       = sh_d;
          bit_cnt_d    = '0;
        end
      end else if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = sh_d;
        bit_cnt_d    = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      run_q        <= '0;
      latch_q      <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      one_seen_q   <= 1'b0;
      carrier_q    <= 1'b0;
      bit_valid_q  <= 1'b0;
      bit_val_q    <= 1'b0;
      sh_q         <= '0;
      bit_cnt_q    <= '0;
      synced_q     <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
    end else begin
      sync1_q      <= tape_in;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      run_q        <= run_d;
      latch_q      <= latch_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      one_seen_q   <= one_seen_d;
      carrier_q    <= carrier_d;
      bit_valid_q  <= bit_valid_d;
      bit_val_q    <= bit_val_d;
      sh_q         <= sh_d;
      bit_cnt_q    <= bit_cnt_d;
      synced_q     <= synced_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
    end
  end

`ifdef TAPE_IN_ERRCNT_EN
  logic       glitch;
  logic [7:0] err_q, err_d;

  // Any CELL rise that neither ends the cell nor is the first data pulse counts as a glitch.
  assign glitch = in_cell && rise && !cell_end && !data_hit;

  always_comb begin
    err_d = err_q;
    if ((glitch || timeout) && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    if (latch_clr) err_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_cnt = err_q;
`endif

  assign tape_level = level_q;
  assign tape_latch = latch_q;
  assign carrier    = carrier_q;
  assign bit_valid  = bit_valid_q;
  assign bit_val    = bit_val_q;
  assign synced     = synced_q;
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_q;

endmodule

// File: tb/tb_tape_in_decoder.sv
// Bench for tape_in_decoder: a default-parameter instance for filter/latch/bit timing, and a
// scaled-time instance for byte alignment, timeout resync and reset mid-byte.
module tb_tape_in_decoder;

  localparam int PW       = 8;     // tape_in pulse width in clocks
  localparam int A_CELL   = 3582;
  localparam int A_HALF   = 1791;
  localparam int A_GLITCH = 1000;
  localparam int B_CELL   = 224;
  localparam int B_HALF   = 112;
  // Level rises 6 clocks after the first high sample; carrier drops TIMEOUT ce ticks later.
  localparam int A_TO_CLKS = 6 + 32'h1C00;
  localparam int B_TO_CLKS = 6 + 32'h01C0;

  logic clock = 1'b0;
  logic reset, ce, motor, latch_clr, tape_in_a, tape_in_b;

  logic a_tape_level, a_tape_latch, a_carrier, a_bit_valid, a_bit_val, a_synced, a_byte_valid;
  logic [7:0] a_byte_data;
  logic b_tape_level, b_tape_latch, b_carrier, b_bit_valid, b_bit_val, b_synced, b_byte_valid;
  logic [7:0] b_byte_data;
`ifdef TAPE_IN_ERRCNT_EN
  logic [7:0] a_err, b_err;
`endif

  tape_in_decoder dut_a (
    .clock(clock), .reset(reset), .ce(ce), .tape_in(tape_in_a), .motor(motor),
    .latch_clr(latch_clr), .tape_level(a_tape_level), .tape_latch(a_tape_latch),
    .carrier(a_carrier), .bit_valid(a_bit_valid), .bit_val(a_bit_val), .synced(a_synced),
    .byte_valid(a_byte_valid), .byte_data(a_byte_data)
`ifdef TAPE_IN_ERRCNT_EN
    , .err_cnt(a_err)
`endif
  );

  tape_in_decoder #(
    .ONE_LO(13'h0050), .ONE_HI(13'h0090), .CELL_LO(13'h00C0), .TIMEOUT(13'h01C0)
  ) dut_b (
    .clock(clock), .reset(reset), .ce(ce), .tape_in(tape_in_b), .motor(motor),
    .latch_clr(latch_clr), .tape_level(b_tape_level), .tape_latch(b_tape_latch),
    .carrier(b_carrier), .bit_valid(b_bit_valid), .bit_val(b_bit_val), .synced(b_synced),
    .byte_valid(b_byte_valid), .byte_data(b_byte_data)
`ifdef TAPE_IN_ERRCNT_EN
    , .err_cnt(b_err)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs_a();
    return {a_tape_level, a_tape_latch, a_carrier, a_bit_valid, a_bit_val, a_synced,
            a_byte_valid, a_byte_data};
  endfunction

  function automatic logic [14:0] outs_b();
    return {b_tape_level, b_tape_latch, b_carrier, b_bit_valid, b_bit_val, b_synced,
            b_byte_valid, b_byte_data};
  endfunction

  // Scoreboards: expectations pushed as stimulus is driven, popped on DUT strobes.
  logic       exp_bits_a[$];
  logic       exp_bits_b[$];
  logic [7:0] exp_bytes_b[$];

  always @(negedge clock) begin
    if (a_bit_valid) begin
      if (exp_bits_a.size() == 0) check("a unexpected bit_valid", a_bit_valid, 0);
      else check("a bit_val", a_bit_val, exp_bits_a.pop_front());
    end
    if (a_byte_valid) check("a unexpected byte_valid", a_byte_valid, 0);
    if (b_bit_valid) begin
      if (exp_bits_b.size() == 0) check("b unexpected bit_valid", b_bit_valid, 0);
      else check("b bit_val", b_bit_val, exp_bits_b.pop_front());
    end
    if (b_byte_valid) begin
      check("b synced with byte_valid", b_synced, 1);
      if (exp_bytes_b.size() == 0) check("b unexpected byte_valid", b_byte_valid, 0);
      else check("b byte_data", b_byte_data, exp_bytes_b.pop_front());
    end
  end

  typedef struct {
    logic tin, mot, clr, lvl, lat;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input int n, input logic tin, input logic mot, input logic clr,
                     input logic lvl, input logic lat);
    vec_t v;
    v.tin = tin; v.mot = mot; v.clr = clr; v.lvl = lvl; v.lat = lat;
    repeat (n) vecs.push_back(v);
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_tin(input bit sel, input logic v);
    if (sel) tape_in_b = v;
    else     tape_in_a = v;
  endtask

  // One pulse; the next rising edge of tape_in comes gap clocks after this one.
  task automatic pulse(input bit sel, input int gap);
    set_tin(sel, 1'b1);
    clocks(PW);
    set_tin(sel, 1'b0);
    clocks(gap - PW);
  endtask

  // Final pulse closes the open cell, then no more pulses: wait (bounded) for carrier loss.
  task automatic final_pulse_timeout(input bit sel, input int exp_n, input string name);
    int n = 0;
    bit done = 1'b0;
    set_tin(sel, 1'b1);
    while (!done && n < exp_n + 100) begin
      @(posedge clock);
      #1;
      n++;
      if (n == PW) set_tin(sel, 1'b0);
      done = sel ? !b_carrier : !a_carrier;
    end
    set_tin(sel, 1'b0);
    check({name, " clocks to carrier loss"}, n, exp_n);
    check({name, " carrier after timeout"}, sel ? b_carrier : a_carrier, 0);
    check({name, " synced after timeout"}, sel ? b_synced : a_synced, 0);
  endtask

  bit   b_open = 1'b0;
  logic b_cur  = 1'b0;

  // Scaled instance: each call closes the previous cell (if any) and drives a cell encoding bv.
  task automatic b_cell(input logic bv);
    if (b_open) exp_bits_b.push_back(b_cur);
    b_open = 1'b1;
    b_cur  = bv;
    if (bv) begin
      pulse(1, B_HALF);
      pulse(1, B_HALF);
    end else begin
      pulse(1, B_CELL);
    end
  endtask

  task automatic send_byte_b(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) b_cell(v[i]);
  endtask

  task automatic b_close_timeout(input string name);
    if (b_open) exp_bits_b.push_back(b_cur);
    b_open = 1'b0;
    final_pulse_timeout(1, B_TO_CLKS, name);
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; motor = 1'b1; latch_clr = 1'b0;
    tape_in_a = 1'b0; tape_in_b = 1'b0;
    clocks(2);
    reset = 1'b0;
    check("reset outputs a", outs_a(), 0);
    check("reset outputs b", outs_b(), 0);
`ifdef TAPE_IN_ERRCNT_EN
    check("reset err_cnt a", a_err, 0);
`endif

    // Filter and latch: one row per clock, ce held high.
    add(3, 1, 1, 0, 0, 0); add(5, 0, 1, 0, 0, 0);                          // 3-clock blip rejected
    add(5, 1, 1, 0, 0, 0); add(5, 1, 1, 0, 1, 1);                          // level at 6th clock
    add(5, 0, 1, 0, 1, 1); add(10, 0, 1, 0, 0, 1);                         // level falls, latch holds
    add(1, 0, 1, 1, 0, 0); add(1, 0, 1, 0, 0, 0);                          // latch_clr 20 clocks after rise
    add(5, 1, 1, 0, 0, 0); add(1, 1, 1, 1, 1, 1); add(2, 1, 1, 0, 1, 1);   // clear coincident with rise
    add(2, 1, 0, 0, 1, 0); add(1, 1, 1, 0, 1, 0);                          // motor off forces latch low
    add(5, 0, 1, 0, 1, 0); add(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      tape_in_a = vecs[i].tin; tape_in_b = vecs[i].tin;
      motor = vecs[i].mot; latch_clr = vecs[i].clr;
      clocks(1);
      check($sformatf("tape_level row %0d", i + 1), a_tape_level, vecs[i].lvl);
      check($sformatf("tape_latch row %0d", i + 1), a_tape_latch, vecs[i].lat);
    end
    tape_in_a = 1'b0; tape_in_b = 1'b0; motor = 1'b1; latch_clr = 1'b0;
    reset = 1'b1; clocks(1); reset = 1'b0;

    // Bit decode with the default cell timing.
    pulse(0, A_CELL);
    check("a carrier after first pulse", a_carrier, 1);
    exp_bits_a.push_back(1'b0); pulse(0, A_HALF);
    pulse(0, A_HALF);
    exp_bits_a.push_back(1'b1); pulse(0, A_GLITCH);
    pulse(0, A_CELL - A_GLITCH);
    check("a carrier after glitch", a_carrier, 1);
    check("a tape_latch after pulses", a_tape_latch, 1);
`ifdef TAPE_IN_ERRCNT_EN
    check("a err_cnt after glitch", a_err, 1);
`endif
    exp_bits_a.push_back(1'b0);
    final_pulse_timeout(0, A_TO_CLKS, "a");
`ifdef TAPE_IN_ERRCNT_EN
    check("a err_cnt after timeout", a_err, 2);
`endif
    latch_clr = 1'b1; clocks(1); latch_clr = 1'b0;
    check("a tape_latch after latch_clr", a_tape_latch, 0);
`ifdef TAPE_IN_ERRCNT_EN
    check("a err_cnt after latch_clr", a_err, 0);
`endif
    check("a bit scoreboard drained", exp_bits_a.size(), 0);

    // Alignment on the scaled instance.
    send_byte_b(8'h00);
    check("b synced after 0x00", b_synced, 0);
    exp_bytes_b.push_back(8'h66);
    send_byte_b(8'h66);
    check("b synced before last sync bit closes", b_synced, 0);
    exp_bytes_b.push_back(8'hA5);
    send_byte_b(8'hA5);
    check("b synced after 0x66", b_synced, 1);
    exp_bytes_b.push_back(8'h3C);
    send_byte_b(8'h3C);
    b_cell(1'b1); b_cell(1'b0); b_cell(1'b1);
    b_close_timeout("b mid-byte");

    // Resync after carrier loss, then reset with ce low four bits into a byte.
    exp_bytes_b.push_back(8'h66);
    send_byte_b(8'h66);
    exp_bytes_b.push_back(8'h5A);
    send_byte_b(8'h5A);
    b_cell(1'b1); b_cell(1'b1); b_cell(1'b0); b_cell(1'b0); b_cell(1'b1);
    check("b synced before reset", b_synced, 1);
    check("b carrier before reset", b_carrier, 1);
    ce = 1'b0; reset = 1'b1;
    clocks(1);
    check("b outputs after mid-byte reset", outs_b(), 0);
`ifdef TAPE_IN_ERRCNT_EN
    check("b err_cnt after mid-byte reset", b_err, 0);
`endif
    reset = 1'b0; ce = 1'b1;
    b_open = 1'b0;
    send_byte_b(8'hA5);
    check("b synced after reset and 0xA5", b_synced, 0);
    exp_bytes_b.push_back(8'h66);
    send_byte_b(8'h66);
    exp_bytes_b.push_back(8'h81);
    send_byte_b(8'h81);
    b_close_timeout("b end");

    check("b bit scoreboard drained", exp_bits_b.size(), 0);
    check("b byte scoreboard drained", exp_bytes_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
